// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing,
// slave wait-state timeout and a registered completion pulse per requester.
module apb_master_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic        WRITE0,
    input  logic        WRITE1,
    input  logic [31:0] ADDR0,
    input  logic [31:0] ADDR1,
    input  logic [31:0] WDATA0,
    input  logic [31:0] WDATA1,
    output logic        ACK0,
    output logic        ACK1,
    output logic [31:0] RDATA,
    output logic        ERR,
    output logic        PSELx,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_last;
    logic        r_gnt;
    logic [7:0]  r_wait;
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic [31:0] r_rdata;
    logic        r_ack0;
    logic        r_ack1;
    logic        r_err;

    logic        w_elig0;
    logic        w_elig1;
    logic        w_any;
    logic        w_pick;
    logic        w_timeout;

    // A requester being acknowledged this cycle sits out this arbitration.
    assign w_elig0   = REQ0 & ~r_ack0;
    assign w_elig1   = REQ1 & ~r_ack1;
    assign w_any     = w_elig0 | w_elig1;
    assign w_pick    = w_elig1 & (~w_elig0 | ~r_last);
    assign w_timeout = (r_wait == LP_LAST_WAIT);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_gnt     <= 1'b0;
            r_wait    <= 8'd0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= 32'd0;
            r_pwdata  <= 32'd0;
            r_rdata   <= 32'd0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt     <= w_pick;
                        r_pwrite  <= w_pick ? WRITE1 : WRITE0;
                        r_paddr   <= w_pick ? ADDR1 : ADDR0;
                        r_pwdata  <= w_pick ? WDATA1 : WDATA0;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_wait    <= 8'd0;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        r_ack0    <= ~r_gnt;
                        r_ack1    <= r_gnt;
                        r_err     <= PSLVERR;
                        if (!r_pwrite) begin
                            r_rdata <= PRDATA;
                        end
                        r_last    <= r_gnt;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (w_timeout) begin
                        r_ack0    <= ~r_gnt;
                        r_ack1    <= r_gnt;
                        r_err     <= 1'b1;
                        r_last    <= r_gnt;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign ACK0    = r_ack0;
    assign ACK1    = r_ack1;
    assign RDATA   = r_rdata;
    assign ERR     = r_err;
    assign PSELx   = r_psel;
    assign PENABLE = r_penable;
    assign PWRITE  = r_pwrite;
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: vector table of single transfers, a model
// slave with programmable wait states, and a completion scoreboard.
module tb_apb_master_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        REQ0, REQ1, WRITE0, WRITE1;
    logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1;
    logic        ACK0, ACK1, ERR, PSELx, PENABLE, PWRITE;
    logic [31:0] RDATA, PADDR, PWDATA;
    logic [31:0] PRDATA = 32'd0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    apb_master_arbiter #(.TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .REQ0(REQ0), .REQ1(REQ1),
        .WRITE0(WRITE0), .WRITE1(WRITE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1),
        .WDATA0(WDATA0), .WDATA1(WDATA1),
        .ACK0(ACK0), .ACK1(ACK1),
        .RDATA(RDATA), .ERR(ERR),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        bit          who;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        bit          slverr;
        bit          noise;
        logic [31:0] prdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        bit          who;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_bad = 0;

    int          sl_waits = 0;
    int          sl_cnt = 0;
    bit          sl_slverr = 0;
    bit          sl_noise = 0;
    logic [31:0] sl_prdata = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    function automatic vec_t mk(bit who, bit wr, logic [31:0] addr,
                                logic [31:0] wdata, int waits, bit slverr,
                                bit noise, logic [31:0] prdata, bit exp_err,
                                logic [31:0] exp_rdata, int exp_lat);
        vec_t v;
        v.who = who; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.waits = waits; v.slverr = slverr; v.noise = noise;
        v.prdata = prdata; v.exp_err = exp_err;
        v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
        return v;
    endfunction

    function automatic exp_t mk_exp(bit who, bit wr, logic [31:0] addr,
                                    logic [31:0] wdata, bit err,
                                    logic [31:0] rdata);
        exp_t e;
        e.who = who; e.wr = wr; e.addr = addr; e.wdata = wdata;
        e.err = err; e.rdata = rdata;
        return e;
    endfunction

    // Model APB slave: inserts sl_waits not-ready ACCESS cycles, then responds.
    always @(negedge PCLK) begin
        if (PSELx && PENABLE && !PRESET) begin
            if (sl_cnt < sl_waits) begin
                PREADY = 1'b0;
                PSLVERR = sl_noise;
                PRDATA = 32'h0;
                sl_cnt++;
            end else begin
                PREADY = 1'b1;
                PSLVERR = sl_slverr;
                PRDATA = sl_prdata;
            end
        end else begin
            PREADY = 1'b0;
            PSLVERR = 1'b0;
            sl_cnt = 0;
        end
    end

    // Scoreboard monitor: bus contents while selected, completion on ACK.
    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (ACK0 && ACK1) chk("ack_both", 32'd1, 32'd0);
            if (PSELx) begin
                if (q.size() == 0) begin
                    chk("bus_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("paddr", PADDR, q[0].addr);
                    chk("pwrite", {31'd0, PWRITE}, {31'd0, q[0].wr});
                    if (q[0].wr) chk("pwdata", PWDATA, q[0].wdata);
                end
            end
            if (ACK0 || ACK1) begin
                if (q.size() == 0) begin
                    chk("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ack_who", {31'd0, ACK1}, {31'd0, e.who});
                    chk("err", {31'd0, ERR}, {31'd0, e.err});
                    chk("rdata", RDATA, e.rdata);
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_psel"}, {31'd0, PSELx}, 32'd0);
        chk({tag, "_penable"}, {31'd0, PENABLE}, 32'd0);
        chk({tag, "_pwrite"}, {31'd0, PWRITE}, 32'd0);
        chk({tag, "_paddr"}, PADDR, 32'd0);
        chk({tag, "_pwdata"}, PWDATA, 32'd0);
        chk({tag, "_ack"}, {30'd0, ACK1, ACK0}, 32'd0);
        chk({tag, "_rdata"}, RDATA, 32'd0);
        chk({tag, "_err"}, {31'd0, ERR}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        bit got;
        @(negedge PCLK);
        sl_waits = v.waits;
        sl_slverr = v.slverr;
        sl_noise = v.noise;
        sl_prdata = v.prdata;
        q.push_back(mk_exp(v.who, v.wr, v.addr, v.wdata,
                           v.exp_err, v.exp_rdata));
        if (v.who) begin
            REQ1 = 1'b1; WRITE1 = v.wr; ADDR1 = v.addr; WDATA1 = v.wdata;
        end else begin
            REQ0 = 1'b1; WRITE0 = v.wr; ADDR0 = v.addr; WDATA0 = v.wdata;
        end
        cyc = 0;
        got = 0;
        while (!got && cyc < 60) begin
            @(negedge PCLK);
            cyc++;
            if (cyc == 1) begin
                // Inputs moving after the grant must not reach the bus.
                REQ0 = 1'b0; REQ1 = 1'b0;
                WRITE0 = ~v.wr; WRITE1 = ~v.wr;
                ADDR0 = v.addr ^ 32'hFFFF_0000;
                ADDR1 = v.addr ^ 32'h0000_FFFF;
                WDATA0 = ~v.wdata; WDATA1 = ~v.wdata;
            end
            if (ACK0 || ACK1) got = 1;
        end
        chk($sformatf("lat_v%0d", idx), cyc, v.exp_lat);
        if (!got) q.delete();
    endtask

    vec_t vt[9];

    initial begin
        int cyc;
        int nack;
        int last_ack;
        int guard;

        vt[0] = mk(0, 1, 32'h8,  32'h1234,     0,   0, 0, 32'h0,
                   0, 32'h0, 3);
        vt[1] = mk(1, 0, 32'h4,  32'h0,        2,   0, 0, 32'hDEADBEEF,
                   0, 32'hDEADBEEF, 5);
        vt[2] = mk(0, 1, 32'hC,  32'h5555AAAA, 0,   1, 0, 32'h0,
                   1, 32'hDEADBEEF, 3);
        vt[3] = mk(1, 1, 32'h20, 32'h0F0F0F0F, 2,   0, 1, 32'h0,
                   0, 32'hDEADBEEF, 5);
        vt[4] = mk(0, 0, 32'h10, 32'h0,        1,   1, 0, 32'h0BADF00D,
                   1, 32'h0BADF00D, 4);
        vt[5] = mk(1, 0, 32'h30, 32'h0,        255, 0, 0, 32'h55,
                   1, 32'h0BADF00D, 18);
        vt[6] = mk(0, 0, 32'h44, 32'h0,        0,   0, 0, 32'hCAFE0001,
                   0, 32'hCAFE0001, 3);
        vt[7] = mk(1, 1, 32'h48, 32'h87654321, 3,   0, 0, 32'h0,
                   0, 32'hCAFE0001, 6);
        vt[8] = mk(0, 0, 32'h4C, 32'h0,        15,  0, 0, 32'h12345678,
                   0, 32'h12345678, 18);

        PRESET = 1'b1;
        REQ0 = 0; REQ1 = 0; WRITE0 = 0; WRITE1 = 0;
        ADDR0 = 0; ADDR1 = 0; WDATA0 = 0; WDATA1 = 0;
        #12;
        chk_reset_vals("por");
        @(negedge PCLK);
        PRESET = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vt[i], i);

        // Reset while a transfer is stalled in ACCESS.
        @(negedge PCLK);
        sl_waits = 255;
        q.push_back(mk_exp(0, 0, 32'h40, 32'h0, 1, 32'h0));
        REQ0 = 1'b1; WRITE0 = 1'b0; ADDR0 = 32'h40;
        guard = 0;
        while (!(PSELx && PENABLE) && guard < 10) begin
            @(negedge PCLK);
            guard++;
        end
        chk("access_reached", {31'd0, PSELx & PENABLE}, 32'd1);
        @(negedge PCLK);
        #2 PRESET = 1'b1;
        #1;
        chk_reset_vals("midrst");
        q.delete();
        REQ0 = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("no_ack_after_rst", {30'd0, ACK1, ACK0}, 32'd0);
        end

        // Both requesters held: alternate grants with no idle gap.
        @(negedge PCLK);
        sl_waits = 0;
        sl_slverr = 0;
        sl_noise = 0;
        sl_prdata = 32'hA5A50001;
        q.push_back(mk_exp(0, 1, 32'h100, 32'h11, 0, 32'h0));
        q.push_back(mk_exp(1, 0, 32'h200, 32'h0,  0, 32'hA5A50001));
        q.push_back(mk_exp(0, 1, 32'h100, 32'h11, 0, 32'hA5A50001));
        q.push_back(mk_exp(1, 0, 32'h200, 32'h0,  0, 32'hA5A50001));
        REQ0 = 1'b1; WRITE0 = 1'b1; ADDR0 = 32'h100; WDATA0 = 32'h11;
        REQ1 = 1'b1; WRITE1 = 1'b0; ADDR1 = 32'h200; WDATA1 = 32'h0;
        cyc = 0;
        nack = 0;
        last_ack = 0;
        while (nack < 4 && cyc < 40) begin
            @(negedge PCLK);
            cyc++;
            if (ACK0 || ACK1) begin
                chk($sformatf("gap_%0d", nack), cyc - last_ack, 32'd3);
                last_ack = cyc;
                nack++;
            end
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        chk("contention_acks", nack, 32'd4);
        repeat (4) @(negedge PCLK);
        chk("queue_empty", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 16: maximum ACCESS-phase cycles allowed without PREADY (legal range 2..255).
REQ-002 SHALL provide port PCLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port PRESET  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide ports REQ0, REQ1  input  1  transfer request from requester 0 / 1.
REQ-005 SHALL provide ports WRITE0, WRITE1  input  1  1 = write, 0 = read, for requester 0 / 1.
REQ-006 SHALL provide ports ADDR0, ADDR1  input  32  transfer address for requester 0 / 1.
REQ-007 SHALL provide ports WDATA0, WDATA1  input  32  write data for requester 0 / 1.
REQ-008 SHALL provide ports ACK0, ACK1  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-009 SHALL provide port RDATA  output  32  read data, valid while ACK0 or ACK1 is high.
REQ-010 SHALL provide port ERR  output  1  completion error, valid while ACK0 or ACK1 is high.
REQ-011 SHALL provide ports PSELx, PENABLE, PWRITE  output  1 each  APB master control.
REQ-012 SHALL provide ports PADDR, PWDATA  output  32 each  APB address / write data.
REQ-013 SHALL provide ports PRDATA  input  32, PREADY  input  1, PSLVERR  input  1  APB slave response.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, ACCESS; all outputs registered.
REQ-015 In IDLE with any eligible REQ, SHALL grant one requester, latch its WRITE/ADDR/WDATA into PWRITE/PADDR/PWDATA and enter SETUP next cycle.
REQ-016 Arbitration SHALL be round-robin: if both requesters are eligible, grant the one not served last (LAST pointer); if only one is eligible, grant it.
REQ-017 A requester whose ACK is high in the current cycle SHALL be ineligible in that cycle.
REQ-018 SETUP SHALL last exactly one cycle with PSELx=1, PENABLE=0, then enter ACCESS.
REQ-019 ACCESS SHALL drive PSELx=1, PENABLE=1 and hold PADDR/PWRITE/PWDATA stable until exit.
REQ-020 In ACCESS with PREADY=1: next cycle SHALL pulse ACK of granted requester, set ERR=PSLVERR, load RDATA=PRDATA for reads only (writes leave RDATA unchanged), update LAST, return to IDLE.
REQ-021 PSLVERR SHALL be ignored unless PREADY=1 in ACCESS.
REQ-022 Wait counter SHALL count ACCESS cycles with PREADY=0; after TIMEOUT such consecutive cycles, SHALL terminate: ACK pulse, ERR=1, RDATA unchanged, LAST updated, IDLE.
REQ-023 Wait counter SHALL clear on every entry to SETUP.
REQ-024 Zero-wait latency: REQ sampled in IDLE at edge N -> SETUP N+1 -> ACCESS N+2 -> ACK high after edge N+3.
REQ-025 ACK cycle is IDLE: a pending request from the other requester SHALL be granted in that same cycle (back-to-back, no idle gap).
REQ-026 In IDLE, PSELx=PENABLE=0; PADDR/PWDATA/PWRITE SHALL retain last values.
REQ-027 REQ changes after grant SHALL NOT affect the in-flight transfer; REQ sampled only in IDLE.
REQ-028 ACK0 and ACK1 SHALL never be high simultaneously.

Reset
REQ-029 PRESET high SHALL immediately force state IDLE, PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, ACK0=ACK1=0, RDATA=0, ERR=0, wait counter 0, LAST=1 (requester 0 wins first tie).
REQ-030 Reset during SETUP/ACCESS SHALL abort the transfer with no ACK issued; first post-reset grant follows REQ-016.

Verification
REQ-031 Write, zero wait: REQ0=1, WRITE0=1, ADDR0=0x8, WDATA0=0x1234, PREADY=1 -> SETUP then ACCESS with PADDR=0x8, PWDATA=0x1234; ACK0 3 cycles after sampling, ERR=0.
REQ-032 Read, 2 wait states: REQ1 read ADDR1=0x4, PREADY low 2 ACCESS cycles then high with PRDATA=0xDEADBEEF -> ACK1, RDATA=0xDEADBEEF, ERR=0.
REQ-033 Contention: REQ0=REQ1=1 held after reset -> grants 0,1,0,1 back-to-back, no IDLE gap, ACKs alternate.
REQ-034 Slave error: write with PREADY=1, PSLVERR=1 -> ACK with ERR=1; PSLVERR=1 while PREADY=0 -> no effect.
REQ-035 Timeout: TIMEOUT=16, PREADY held 0 -> ACK after 16 ACCESS cycles, ERR=1, RDATA unchanged.
REQ-036 Reset mid-ACCESS: PRESET pulsed -> PSELx/PENABLE 0 asynchronously, no ACK, all outputs at REQ-029 values.
